inst_sequencer: RTL and testbench

- Generates the 34-bit instruction word consumed by the accelerator core, i.e. the issuing end of the core's inst interface.
- For one kernel position it sequences the following phases:
  - weight fetch from xmem into L0;
  - weight load into the PE array;
  - activation fetch into L0;
  - execute;
  - OFIFO drain into pmem.
- It sits between the top-level test/host control and core, and pauses the drain on ofifo_valid.

---
 rtl/inst_sequencer.sv | 133 +++++++++++++
 tb/tb_inst_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// inst_sequencer: issues the 34-bit core instruction word for one kernel position
//   (weight fetch -> L0, array load, settle gap, activation fetch -> L0, execute,
//   OFIFO drain -> pmem).
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   start        one-cycle pulse, begins a pass when idle
//   w_base       xmem base address of weights       (latched on start)
//   act_base     xmem base address of activations   (latched on start)
//   psum_base    pmem base address of outputs       (latched on start)
//   acc_en       accumulate flag for pmem writes    (latched on start)
//   ofifo_valid  OFIFO has data; drain reads only when high
//   inst         registered instruction word to core
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse at end of pass
module inst_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 36,
    parameter int gap     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] w_base,
    input  logic [10:0] act_base,
    input  logic [10:0] psum_base,
    input  logic        acc_en,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);
    if (row < 1 || col < 1 || len_nij < 1 || gap < 1) begin : g_bad_params
        $error("inst_sequencer: all size parameters must be at least 1");
    end

    localparam int cmax = col > gap ? (col > len_nij ? col : len_nij)
                                    : (gap > len_nij ? gap : len_nij);
    localparam int cw = $clog2(cmax + 1);
    localparam int dw = $clog2(len_nij + 1);
    localparam logic [33:0] idle_word = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

    typedef enum logic [3:0] {
        S_IDLE, S_W_RD, S_W_FL, S_LOAD, S_GAP, S_A_RD, S_A_FL, S_EXEC, S_DRAIN, S_FIN
    } state_t;

    state_t          state;
    logic [cw-1:0]   cnt, term;
    logic [dw-1:0]   rd_cnt, wr_cnt;
    logic            pend, rd, last, last_wr, acc;
    logic [10:0]     wb, ab, pb;
    logic [33:0]     inst_d;

    always_comb begin
        rd      = state == S_DRAIN && ofifo_valid && rd_cnt != dw'(len_nij);
        last_wr = pend && wr_cnt == dw'(len_nij - 1);
        // single-cycle states (and IDLE/DRAIN) use terminal 0, so cnt parks at 0
        term = (state == S_W_RD || state == S_LOAD) ? cw'(col - 1) :
               state == S_GAP                       ? cw'(gap - 1) :
               (state == S_A_RD || state == S_EXEC) ? cw'(len_nij - 1) : '0;
        last   = cnt == term;
        inst_d = idle_word;
        case (state)
            S_W_RD, S_A_RD: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = (state == S_W_RD ? wb : ab) + 11'(cnt);
                // SRAM data lags the address by one cycle
                inst_d[2]    = cnt != '0;
            end
            S_W_FL, S_A_FL: inst_d[2] = 1'b1;
            S_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_DRAIN: begin
                // read of this cycle and write of the previous read share a word
                inst_d[6] = rd;
                if (pend) begin
                    inst_d[33]    = acc;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = pb + 11'(wr_cnt);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            pend   <= 1'b0;
            wb     <= '0;
            ab     <= '0;
            pb     <= '0;
            acc    <= 1'b0;
            inst   <= idle_word;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            inst   <= inst_d;
            done   <= state == S_FIN;
            busy   <= state == S_IDLE ? start : state != S_FIN;
            cnt    <= last ? '0 : cnt + 1'b1;
            pend   <= rd;
            rd_cnt <= state == S_DRAIN ? rd_cnt + dw'(rd) : '0;
            wr_cnt <= state == S_DRAIN ? wr_cnt + dw'(pend) : '0;
            if (state == S_IDLE) begin
                if (start) begin
                    wb    <= w_base;
                    ab    <= act_base;
                    pb    <= psum_base;
                    acc   <= acc_en;
                    state <= S_W_RD;
                end
            end else if (state == S_DRAIN) begin
                if (last_wr) state <= S_FIN;
            end else if (state == S_FIN) begin
                state <= S_IDLE;
            end else if (last) begin
                state <= state_t'(state + 4'd1);
            end
        end
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: scoreboard bench for inst_sequencer; expected {busy,done,inst}
//   per cycle is queued when a pass is started and compared as the DUT runs.
module tb_inst_sequencer;
    localparam int C = 8;
    localparam int G = 16;
    localparam int L = 36;
    localparam int LAT = 1 + (C + 1) + C + G + (L + 1) + L + (L + 1) + 1;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, acc_en = 1'b0, ofifo_valid = 1'b0;
    logic [10:0] w_base = '0, act_base = '0, psum_base = '0;
    logic [33:0] inst;
    logic        busy, done;
    int          checks = 0, errors = 0;
    logic [35:0] exp_q[$];

    inst_sequencer #(.row(8), .col(C), .len_nij(L), .gap(G)) dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .act_base(act_base),
        .psum_base(psum_base), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mkw(input logic a, cenp, wenp, input logic [10:0] ap,
                                        input logic cenx, wenx, input logic [10:0] ax,
                                        input logic ofr, l0r, l0w, ex, ld);
        return {a, cenp, wenp, ap, cenx, wenx, ax, ofr, 1'b0, 1'b0, l0r, l0w, ex, ld};
    endfunction

    function automatic logic pat(input int mode, input int o);
        return mode == 0 ? 1'b1 : (o % 4 == 0 || o % 4 == 3);
    endfunction

    logic [33:0] idle_w;
    initial idle_w = mkw(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    task automatic build(input logic [10:0] wb, ab, pb, input logic acc, input int mode);
        int o, reads, writes;
        logic pend, v, rd, fin;
        exp_q.delete();
        exp_q.push_back({2'b10, idle_w});
        for (int i = 0; i < C; i++)
            exp_q.push_back({2'b10, mkw(0, 1, 1, 0, 0, 1, wb + 11'(i), 0, 0, i != 0, 0, 0)});
        exp_q.push_back({2'b10, mkw(0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0)});
        for (int i = 0; i < C; i++)
            exp_q.push_back({2'b10, mkw(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1)});
        for (int i = 0; i < G; i++)
            exp_q.push_back({2'b10, idle_w});
        for (int i = 0; i < L; i++)
            exp_q.push_back({2'b10, mkw(0, 1, 1, 0, 0, 1, ab + 11'(i), 0, 0, i != 0, 0, 0)});
        exp_q.push_back({2'b10, mkw(0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0)});
        for (int i = 0; i < L; i++)
            exp_q.push_back({2'b10, mkw(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0)});
        o = 1 + C + 1 + C + G + L + 1 + L;
        reads = 0;
        writes = 0;
        pend = 1'b0;
        fin = 1'b0;
        while (!fin) begin
            v = pat(mode, o);
            rd = v && reads < L;
            fin = pend && writes == L - 1;
            exp_q.push_back({2'b10, mkw(pend ? acc : 1'b0, !pend, !pend,
                                        pend ? pb + 11'(writes) : 11'd0, 1, 1, 0, rd, 0, 0, 0, 0)});
            writes += int'(pend);
            reads += int'(rd);
            pend = rd;
            o++;
        end
        exp_q.push_back({2'b01, idle_w});
    endtask

    task automatic run_pass(input logic [10:0] wb, ab, pb, input logic acc, input int mode,
                            input int poke);
        int n, wr, dn_at;
        logic [35:0] e;
        build(wb, ab, pb, acc, mode);
        n = exp_q.size();
        @(posedge clk); #1;
        w_base = wb;
        act_base = ab;
        psum_base = pb;
        acc_en = acc;
        start = 1'b1;
        ofifo_valid = pat(mode, 0);
        @(negedge clk);
        chk("pre_start", {busy, done, inst}, {2'b00, idle_w});
        wr = 0;
        dn_at = 0;
        for (int o = 1; o < 3000 && exp_q.size() > 0; o++) begin
            @(posedge clk); #1;
            start = o == poke;
            w_base = 11'($urandom);
            act_base = 11'($urandom);
            psum_base = 11'($urandom);
            acc_en = 1'($urandom);
            ofifo_valid = pat(mode, o);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("cyc", {busy, done, inst}, e);
            if (!inst[32]) wr++;
            if (done) dn_at = o;
        end
        start = 1'b0;
        chk("drained", exp_q.size(), 0);
        chk("pmem_writes", wr, L);
        chk("latency", dn_at, mode == 0 ? LAT : n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {busy, done, inst}, {2'b00, idle_w});
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {busy, done, inst}, {2'b00, idle_w});
        end
        run_pass(0, 100, 0, 0, 0, -1);
        run_pass(5, 100, 2040, 1, 0, -1);
        run_pass(0, 100, 0, 0, 1, -1);
        run_pass(7, 300, 10, 1, 0, 80);
        run_pass(0, 100, 0, 0, 0, -1);
        // abort a pass in the middle of the activation fetch
        @(posedge clk); #1;
        w_base = 0;
        act_base = 100;
        psum_base = 0;
        acc_en = 0;
        start = 1'b1;
        for (int o = 1; o <= 40; o++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("a_rd_cen", inst[19], 1'b0);
        chk("a_rd_addr", inst[17:7], 11'd105);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort", {busy, done, inst}, {2'b00, idle_w});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort", {busy, done, inst}, {2'b00, idle_w});
        end
        run_pass(0, 100, 0, 0, 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
